// File: rtl/pc_fetch.sv
// Program-counter and instruction-register front end: fetches from a combinational
// ROM, supports stall, absolute/relative redirects with one bubble, and halt.
module pc_fetch #(
  parameter int D = 10,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stall,
  input  logic         jump_en,
  input  logic [D-1:0] jump_addr,
  input  logic         rel_en,
  input  logic [D-1:0] rel_off,
  input  logic         halt,
  input  logic [W-1:0] mach_code,
  output logic [D-1:0] prog_ctr,
  output logic [W-1:0] ir,
  output logic [D-1:0] ir_pc,
  output logic         ir_valid,
  output logic         done,
  output logic [15:0]  cyc_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t       state, state_nxt;
  logic [D-1:0] prog_ctr_nxt, ir_pc_nxt;
  logic [W-1:0] ir_nxt;
  logic         ir_valid_nxt;
  logic [15:0]  cyc_count_nxt;
  logic [D-1:0] rel_target;

  // Relative targets are taken from the address of the instruction in IR,
  // not from prog_ctr, which has already moved one word ahead.
  assign rel_target = ir_pc + rel_off;

  // done is a pure function of the state register, so it has no input path.
  assign done = (state == HALTED);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt     = state;
    prog_ctr_nxt  = prog_ctr;
    ir_nxt        = ir;
    ir_pc_nxt     = ir_pc;
    ir_valid_nxt  = ir_valid;
    cyc_count_nxt = cyc_count;

    unique case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nxt     = RUN;
          prog_ctr_nxt  = '0;
          ir_valid_nxt  = 1'b0;
          cyc_count_nxt = '0;
        end
      end

      RUN: begin
        if (cyc_count != 16'hFFFF) cyc_count_nxt = cyc_count + 16'd1;

        // Control requests belong to the word in IR; with no valid word they are ignored.
        if (ir_valid && halt) begin
          state_nxt    = HALTED;
          ir_valid_nxt = 1'b0;
        end else if (ir_valid && jump_en) begin
          prog_ctr_nxt = jump_addr;
          ir_valid_nxt = 1'b0;
        end else if (ir_valid && rel_en) begin
          prog_ctr_nxt = rel_target;
          ir_valid_nxt = 1'b0;
        end else if (!stall) begin
          ir_nxt       = mach_code;
          ir_pc_nxt    = prog_ctr;
          ir_valid_nxt = 1'b1;
          prog_ctr_nxt = prog_ctr + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prog_ctr  <= '0;
      ir        <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
      cyc_count <= '0;
    end else begin
      state     <= state_nxt;
      prog_ctr  <= prog_ctr_nxt;
      ir        <= ir_nxt;
      ir_pc     <= ir_pc_nxt;
      ir_valid  <= ir_valid_nxt;
      cyc_count <= cyc_count_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, stall, redirects, wrap, halt, reset.
module tb_pc_fetch;

  localparam int D = 10;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, stall, jump_en, rel_en, halt;
  logic [D-1:0] jump_addr, rel_off;
  logic [W-1:0] mach_code;
  logic [D-1:0] prog_ctr, ir_pc;
  logic [W-1:0] ir;
  logic         ir_valid, done;
  logic [15:0]  cyc_count;

  int errors = 0;
  int checks = 0;
  logic        in_run = 1'b0;
  logic [15:0] exp_cyc = '0;

  pc_fetch #(.D(D), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .jump_en(jump_en), .jump_addr(jump_addr), .rel_en(rel_en), .rel_off(rel_off),
    .halt(halt), .mach_code(mach_code), .prog_ctr(prog_ctr), .ir(ir),
    .ir_pc(ir_pc), .ir_valid(ir_valid), .done(done), .cyc_count(cyc_count)
  );

  always #5 clk = ~clk;

  // ROM contents: the four program words, then a simple address pattern elsewhere.
  function automatic logic [W-1:0] rom(input logic [D-1:0] a);
    case (a)
      10'd0:   return 9'h07E;
      10'd1:   return 9'h066;
      10'd2:   return 9'h07A;
      10'd3:   return 9'h1DE;
      default: return 9'((a * 3) + 1);
    endcase
  endfunction

  always_comb mach_code = rom(prog_ctr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (in_run) exp_cyc = (exp_cyc == 16'hFFFF) ? exp_cyc : exp_cyc + 16'd1;
    @(negedge clk);
  endtask

  task automatic chk_fetch(input string tag, input logic [D-1:0] pc);
    check({tag, ".ir"}, 32'(ir), 32'(rom(pc)));
    check({tag, ".ir_pc"}, 32'(ir_pc), 32'(pc));
    check({tag, ".valid"}, 32'(ir_valid), 32'd1);
  endtask

  task automatic chk_bubble(input string tag, input logic [D-1:0] pc);
    check({tag, ".valid"}, 32'(ir_valid), 32'd0);
    check({tag, ".pc"}, 32'(prog_ctr), 32'(pc));
  endtask

  task automatic chk_zero(input string tag);
    check({tag, ".pc"}, 32'(prog_ctr), 32'd0);
    check({tag, ".ir"}, 32'(ir), 32'd0);
    check({tag, ".ir_pc"}, 32'(ir_pc), 32'd0);
    check({tag, ".valid"}, 32'(ir_valid), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".cyc"}, 32'(cyc_count), 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    in_run = 1'b1;
    exp_cyc = '0;
  endtask

  task automatic do_jump(input logic [D-1:0] addr);
    jump_en = 1'b1; jump_addr = addr;
    step();
    jump_en = 1'b0;
    chk_bubble("jmp_bubble", addr);
    step();
    chk_fetch("jmp_target", addr);
  endtask

  initial begin
    rst_n = 1'b1;
    {start, stall, jump_en, rel_en, halt} = '0;
    jump_addr = '0; rel_off = '0;

    // Asynchronous reset, then no fetch before start.
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    step(); step();
    chk_zero("idle");

    // Start and sequential fetch of the program words.
    do_start();
    chk_bubble("start", 10'd0);
    check("start.cyc", 32'(cyc_count), 32'd0);
    step(); chk_fetch("seq0", 10'd0);
    check("seq0.cyc", 32'(cyc_count), 32'(exp_cyc));
    step(); chk_fetch("seq1", 10'd1);
    step(); chk_fetch("seq2", 10'd2);

    // Three-cycle stall with ir_pc=2.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_fetch("stall", 10'd2);
      check("stall.pc", 32'(prog_ctr), 32'd3);
    end
    stall = 1'b0;
    step(); chk_fetch("resume", 10'd3);
    check("resume.cyc", 32'(cyc_count), 32'(exp_cyc));

    // Jump overrides stall; a jump request during the bubble is ignored.
    stall = 1'b1; jump_en = 1'b1; jump_addr = 10'h200;
    step();
    stall = 1'b0; jump_addr = 10'h100;
    chk_bubble("jmp_stall", 10'h200);
    step();
    jump_en = 1'b0;
    chk_fetch("jmp200", 10'h200);
    check("jmp200.pc", 32'(prog_ctr), 32'h201);

    // Relative redirect backwards from ir_pc=5.
    do_jump(10'd5);
    rel_en = 1'b1; rel_off = 10'h3FE;
    step();
    rel_en = 1'b0;
    chk_bubble("rel_neg", 10'd3);
    step(); chk_fetch("rel_neg_t", 10'd3);

    // Relative redirect wrapping from ir_pc=0x3FF.
    do_jump(10'h3FF);
    check("pc_wrap", 32'(prog_ctr), 32'd0);
    rel_en = 1'b1; rel_off = 10'd2;
    step();
    rel_en = 1'b0;
    chk_bubble("rel_wrap", 10'd1);
    step(); chk_fetch("rel_wrap_t", 10'd1);

    // Sequential wrap through the top of the address space.
    do_jump(10'h3FE);
    step(); chk_fetch("wrap3ff", 10'h3FF);
    step(); chk_fetch("wrap000", 10'h000);

    // Halt wins over a simultaneous jump.
    halt = 1'b1; jump_en = 1'b1; jump_addr = 10'h123;
    step();
    halt = 1'b0; jump_en = 1'b0;
    in_run = 1'b0;
    check("halt.done", 32'(done), 32'd1);
    chk_bubble("halt", 10'd1);
    check("halt.cyc", 32'(cyc_count), 32'(exp_cyc));
    step(); step();
    check("halted.done", 32'(done), 32'd1);
    chk_bubble("halted", 10'd1);
    check("halted.cyc", 32'(cyc_count), 32'(exp_cyc));

    // Restart from HALTED, then run until cyc_count=20.
    do_start();
    check("restart.done", 32'(done), 32'd0);
    chk_bubble("restart", 10'd0);
    check("restart.cyc", 32'(cyc_count), 32'd0);
    for (int i = 0; i < 20; i++) step();
    check("run20.cyc", 32'(cyc_count), 32'd20);
    check("run20.ir_pc", 32'(ir_pc), 32'd19);

    // Reset mid-run clears everything immediately.
    rst_n = 1'b0;
    in_run = 1'b0; exp_cyc = '0;
    #1 chk_zero("rst_mid");
    @(negedge clk) rst_n = 1'b1;
    step();
    chk_zero("rst_idle");

    // Start after reset restarts at 0; start while running is ignored.
    do_start();
    step(); chk_fetch("post0", 10'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_fetch("start_in_run", 10'd1);
    check("start_in_run.cyc", 32'(cyc_count), 32'(exp_cyc));
    check("start_in_run.val", 32'(exp_cyc), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
